txrx_csr: RTL

- Parametrised CPU register block for the BLE-style transceiver.
- Owns configuration (access address, channel index, enables) and converts CPU commands into single-cycle start pulses.
- Buffers TX and RX payload bytes in independent FIFOs and reports status, levels and interrupts.
- Sits between the CPU bus and the tx / fsk_demod / rx cores, replacing their direct register decode.

---
 rtl/txrx_csr.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/txrx_csr.sv
// CPU register block for the BLE-style transceiver: configuration, command pulses,
// TX/RX payload FIFOs, status and interrupt reporting.
module txrx_csr #(
  parameter int          ADDR_W   = 4,
  parameter int          FIFO_AW  = 3,
  parameter int          CH_IDX_W = 6,
  parameter logic [31:0] AA_RST   = 32'h8E89BED6,
  parameter int          CH_RST   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [31:0]         wdata,
  input  logic                wstrb,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [31:0]         aa,
  output logic [CH_IDX_W-1:0] ch_idx,
  output logic                tx_en,
  output logic                rx_en,
  output logic                demod_en,
  output logic                tx_start,
  output logic                rx_start,
  output logic [7:0]          tx_byte,
  output logic                tx_byte_valid,
  input  logic                tx_byte_ready,
  input  logic [7:0]          rx_byte,
  input  logic                rx_byte_valid,
  input  logic                tx_done,
  input  logic                rx_done,
  output logic                busy,
  output logic                irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LVL_W = FIFO_AW + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_AA     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CH     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_TXD    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RXD    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_IRQEN  = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_IRQST  = ADDR_W'(8);

  // Bus handshake: a request is accepted when valid is high and ready is low;
  // ready then pulses for exactly one cycle with rdata holding the read result.
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [31:0]         aa_q, aa_d;
  logic [CH_IDX_W-1:0] ch_idx_q, ch_idx_d;
  logic [3:0]          irq_en_q, irq_en_d;
  logic [2:0]          irq_stat_q, irq_stat_d;
  logic                irq_q, irq_d;
  logic                busy_q, busy_d;
  logic                op_rx_q, op_rx_d;
  logic                tx_start_q, tx_start_d;
  logic                rx_start_q, rx_start_d;
  logic                flush_tx_q, flush_tx_d;
  logic                flush_rx_q, flush_rx_d;
  logic [FIFO_AW-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [FIFO_AW-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LVL_W-1:0]    tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic                tx_drop_q, tx_drop_d, rx_ovf_q, rx_ovf_d;
  logic [7:0]          tx_mem [DEPTH];
  logic [7:0]          rx_mem [DEPTH];

  logic        accept, wr_acc, rd_acc, cmd_wr, done_hit, busy_free;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push_req, tx_pop_req, tx_push, tx_pop;
  logic        rx_push_req, rx_pop_req, rx_push, rx_pop, rx_ovf_evt;
  logic [7:0]  tx_head, rx_head;
  logic [31:0] rd_val, status;

  assign accept = valid && !ready_q;
  assign wr_acc = accept && wstrb;
  assign rd_acc = accept && !wstrb;
  assign cmd_wr = wr_acc && (address == A_CMD);

  // Only the done pulse of the operation actually in flight releases busy.
  assign done_hit  = busy_q && (op_rx_q ? rx_done : tx_done);
  assign busy_free = !busy_q || done_hit;

  assign tx_empty = (tx_level_q == '0);
  assign tx_full  = (tx_level_q == LVL_FULL);
  assign rx_empty = (rx_level_q == '0);
  assign rx_full  = (rx_level_q == LVL_FULL);
  assign tx_head  = tx_mem[tx_rd_ptr_q];
  assign rx_head  = rx_mem[rx_rd_ptr_q];

  // A push into a full FIFO still succeeds when a pop happens in the same cycle.
  assign tx_push_req = wr_acc && (address == A_TXD);
  assign tx_pop_req  = tx_byte_ready && !tx_empty;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop_req) && !flush_tx_q;
  assign tx_pop      = tx_pop_req && !flush_tx_q;

  assign rx_push_req = rx_byte_valid;
  assign rx_pop_req  = rd_acc && (address == A_RXD) && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop_req) && !flush_rx_q;
  assign rx_pop      = rx_pop_req && !flush_rx_q;
  assign rx_ovf_evt  = rx_push_req && rx_full && !rx_pop_req && !flush_rx_q;

  assign status = {8'h00, 8'(tx_level_q), 8'(rx_level_q), (aa_q != AA_RST), busy_q,
                   tx_drop_q, rx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rd_val = 32'hFFFF_FFFF;
    case (address)
      A_CTRL:  rd_val = {29'd0, ctrl_q};
      A_CMD:   rd_val = 32'd0;
      A_AA:    rd_val = aa_q;
      A_CH:    rd_val = 32'(ch_idx_q);
      A_TXD:   rd_val = 32'd0;
      A_RXD:   rd_val = rx_empty ? 32'd0 : {24'd0, rx_head};
      A_STAT:  rd_val = status;
      A_IRQEN: rd_val = {28'd0, irq_en_q};
      A_IRQST: rd_val = {28'd0, !rx_empty, irq_stat_q};
      default: rd_val = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    ready_d  = accept;
    rdata_d  = rd_acc ? rd_val : rdata_q;
    ctrl_d   = ctrl_q;
    aa_d     = aa_q;
    ch_idx_d = ch_idx_q;
    irq_en_d = irq_en_q;
    if (wr_acc && address == A_CTRL)  ctrl_d   = wdata[2:0];
    if (wr_acc && address == A_AA)    aa_d     = wdata;
    if (wr_acc && address == A_CH)    ch_idx_d = wdata[CH_IDX_W-1:0];
    if (wr_acc && address == A_IRQEN) irq_en_d = wdata[3:0];

    tx_start_d = cmd_wr && wdata[0] && busy_free;
    rx_start_d = cmd_wr && !wdata[0] && wdata[1] && busy_free;
    flush_tx_d = cmd_wr && wdata[2];
    flush_rx_d = cmd_wr && wdata[3];
    busy_d     = (tx_start_d || rx_start_d) ? 1'b1 : (done_hit ? 1'b0 : busy_q);
    op_rx_d    = tx_start_d ? 1'b0 : (rx_start_d ? 1'b1 : op_rx_q);

    // New events win over a same-cycle W1C so none is lost.
    irq_stat_d = irq_stat_q;
    if (wr_acc && address == A_IRQST) irq_stat_d = irq_stat_q & ~wdata[2:0];
    irq_stat_d = irq_stat_d | {rx_ovf_evt, rx_done, tx_done};
    irq_d      = |({!rx_empty, irq_stat_q} & irq_en_q);

    if (flush_tx_q) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_level_d  = '0;
      tx_drop_d   = 1'b0;
    end else begin
      tx_wr_ptr_d = tx_wr_ptr_q + FIFO_AW'(tx_push);
      tx_rd_ptr_d = tx_rd_ptr_q + FIFO_AW'(tx_pop);
      tx_level_d  = tx_level_q + LVL_W'(tx_push) - LVL_W'(tx_pop);
      tx_drop_d   = tx_drop_q || (tx_push_req && tx_full && !tx_pop_req);
    end

    if (flush_rx_q) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_level_d  = '0;
      rx_ovf_d    = 1'b0;
    end else begin
      rx_wr_ptr_d = rx_wr_ptr_q + FIFO_AW'(rx_push);
      rx_rd_ptr_d = rx_rd_ptr_q + FIFO_AW'(rx_pop);
      rx_level_d  = rx_level_q + LVL_W'(rx_push) - LVL_W'(rx_pop);
      rx_ovf_d    = rx_ovf_q || rx_ovf_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      ctrl_q      <= '0;
      aa_q        <= AA_RST;
      ch_idx_q    <= CH_IDX_W'(CH_RST);
      irq_en_q    <= '0;
      irq_stat_q  <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      op_rx_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      rx_start_q  <= 1'b0;
      flush_tx_q  <= 1'b0;
      flush_rx_q  <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
      tx_drop_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      ctrl_q      <= ctrl_d;
      aa_q        <= aa_d;
      ch_idx_q    <= ch_idx_d;
      irq_en_q    <= irq_en_d;
      irq_stat_q  <= irq_stat_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
      op_rx_q     <= op_rx_d;
      tx_start_q  <= tx_start_d;
      rx_start_q  <= rx_start_d;
      flush_tx_q  <= flush_tx_d;
      flush_rx_q  <= flush_rx_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_level_q  <= rx_level_d;
      tx_drop_q   <= tx_drop_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  // Payload storage is not reset; the level counters define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_byte;
  end

  assign rdata         = rdata_q;
  assign ready         = ready_q;
  assign aa            = aa_q;
  assign ch_idx        = ch_idx_q;
  assign tx_en         = ctrl_q[0];
  assign rx_en         = ctrl_q[1];
  assign demod_en      = ctrl_q[2];
  assign tx_start      = tx_start_q;
  assign rx_start      = rx_start_q;
  assign tx_byte       = tx_empty ? 8'h00 : tx_head;
  assign tx_byte_valid = !tx_empty;
  assign busy          = busy_q;
  assign irq           = irq_q;
endmodule
